// File: rtl/mc_fetch_datapath.sv
// mc_fetch_datapath
// State-holding datapath partner of the multicycle MIPS control FSM.
// Owns the program counter, instruction register (IR) and memory data
// register (MDR). Drives the unified instruction/data memory port, which
// supports ready-based wait states.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-low reset
//   PCWrite, Branch,
//   PCSrc, Zero           PC update controls (PCEn = PCWrite | Branch & Zero)
//   IRWrite, lord,
//   MemWrite              memory access controls from the control FSM
//   ALUResult, ALUOut     PC / address sources
//   WriteData             store data
//   mem_rdata, mem_ready  memory read data and access-complete handshake
//   mem_addr, mem_wdata,
//   mem_we, mem_re        memory request (combinational)
//   PC, Instr, Data       architectural registers
//   Opcode, Funct         IR fields returned to the decoders
//   Stall                 memory access pending; all state holds
//   fetch_count           completed instruction fetches (wraps)
module mc_fetch_datapath #(
   parameter int                 WIDTH    = 32,
   parameter logic [WIDTH-1:0]   RESET_PC = 32'h0000_0000,
   parameter int                 CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PCWrite,
   input  logic             Branch,
   input  logic             PCSrc,
   input  logic             IRWrite,
   input  logic             lord,
   input  logic             MemWrite,
   input  logic             Zero,
   input  logic [WIDTH-1:0] ALUResult,
   input  logic [WIDTH-1:0] ALUOut,
   input  logic [WIDTH-1:0] WriteData,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_we,
   output logic             mem_re,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] Instr,
   output logic [5:0]       Opcode,
   output logic [5:0]       Funct,
   output logic [WIDTH-1:0] Data,
   output logic             Stall,
   output logic [CNT_W-1:0] fetch_count
);

   logic [WIDTH-1:0] pc_r;
   logic [WIDTH-1:0] ir_r;
   logic [WIDTH-1:0] mdr_r;
   logic [CNT_W-1:0] fetch_count_r;

   logic             access_s;
   logic             stall_s;
   logic             pc_en_s;
   logic [WIDTH-1:0] pc_next_s;
   logic             ir_load_s;
   logic             mdr_load_s;

   // Memory request, stall detection and register load enables.
   always_comb begin
      mem_addr   = pc_r;
      mem_wdata  = WriteData;
      mem_we     = MemWrite;
      mem_re     = 1'b0;
      access_s   = 1'b0;
      stall_s    = 1'b0;
      pc_en_s    = 1'b0;
      pc_next_s  = ALUResult;
      ir_load_s  = 1'b0;
      mdr_load_s = 1'b0;

      if (lord) begin
         mem_addr = ALUOut;
      end else begin
         mem_addr = pc_r;
      end

      // A write always wins over a read request on the shared port.
      mem_re   = (IRWrite | lord) & ~MemWrite;
      access_s = mem_we | mem_re;
      // Cycles with no memory access (branch/jump) can never stall.
      stall_s  = access_s & ~mem_ready;

      pc_en_s = PCWrite | (Branch & Zero);
      if (PCSrc) begin
         pc_next_s = ALUOut;
      end else begin
         pc_next_s = ALUResult;
      end

      // IR and MDR load only on read cycles, never on a write cycle.
      ir_load_s  = IRWrite & ~MemWrite & ~stall_s;
      mdr_load_s = mem_re & lord & ~stall_s;
   end

   // Architectural state: PC, IR, MDR and retired-fetch counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_r          <= RESET_PC;
         ir_r          <= {WIDTH{1'b0}};
         mdr_r         <= {WIDTH{1'b0}};
         fetch_count_r <= {CNT_W{1'b0}};
      end else begin
         if (pc_en_s && !stall_s) begin
            pc_r <= pc_next_s;
         end
         if (ir_load_s) begin
            ir_r          <= mem_rdata;
            fetch_count_r <= fetch_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (mdr_load_s) begin
            mdr_r <= mem_rdata;
         end
      end
   end

   assign PC          = pc_r;
   assign Instr       = ir_r;
   assign Opcode      = ir_r[31:26];
   assign Funct       = ir_r[5:0];
   assign Data        = mdr_r;
   assign Stall       = stall_s;
   assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_mc_fetch_datapath.sv
module tb_mc_fetch_datapath;

   logic        clk;
   logic        rst;
   logic        PCWrite;
   logic        Branch;
   logic        PCSrc;
   logic        IRWrite;
   logic        lord;
   logic        MemWrite;
   logic        Zero;
   logic [31:0] ALUResult;
   logic [31:0] ALUOut;
   logic [31:0] WriteData;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic [5:0]  Opcode;
   logic [5:0]  Funct;
   logic [31:0] Data;
   logic        Stall;
   logic [31:0] fetch_count;

   int tests_run;
   int tests_failed;

   mc_fetch_datapath #(
      .WIDTH    (32),
      .RESET_PC (32'h0000_0000),
      .CNT_W    (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .PCWrite     (PCWrite),
      .Branch      (Branch),
      .PCSrc       (PCSrc),
      .IRWrite     (IRWrite),
      .lord        (lord),
      .MemWrite    (MemWrite),
      .Zero        (Zero),
      .ALUResult   (ALUResult),
      .ALUOut      (ALUOut),
      .WriteData   (WriteData),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_re      (mem_re),
      .PC          (PC),
      .Instr       (Instr),
      .Opcode      (Opcode),
      .Funct       (Funct),
      .Data        (Data),
      .Stall       (Stall),
      .fetch_count (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      PCWrite   = 1'b0;
      Branch    = 1'b0;
      PCSrc     = 1'b0;
      IRWrite   = 1'b0;
      lord      = 1'b0;
      MemWrite  = 1'b0;
      Zero      = 1'b0;
      mem_ready = 1'b1;
   endtask

   task automatic test_reset();
      // Asynchronous assertion at t=3, checked before the first edge at t=5.
      #3 rst = 1'b0;
      #1;
      tests_run++;
      if (PC !== 32'h0 || Instr !== 32'h0 || Opcode !== 6'h00 ||
          Data !== 32'h0 || fetch_count !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset: PC=%h Instr=%h Opcode=%h Data=%h cnt=%0d, required all zero",
                  PC, Instr, Opcode, Data, fetch_count);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_fetch_zero_wait();
      @(negedge clk);
      idle_inputs();
      IRWrite   = 1'b1;
      PCWrite   = 1'b1;
      ALUResult = 32'h0000_0004;
      mem_rdata = 32'h8C08_0004;
      #1;
      tests_run++;
      if (mem_addr !== 32'h0 || mem_re !== 1'b1 || mem_we !== 1'b0 || Stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL fetch0_port: addr=%h re=%b we=%b stall=%b, required 0 1 0 0",
                  mem_addr, mem_re, mem_we, Stall);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (Instr !== 32'h8C08_0004 || Opcode !== 6'b100011 || Funct !== 6'b000100) begin
         tests_failed++;
         $display("FAIL fetch0_ir: Instr=%h Opcode=%b Funct=%b, required 8c080004 100011 000100",
                  Instr, Opcode, Funct);
      end
      tests_run++;
      if (PC !== 32'h4 || fetch_count !== 32'd1) begin
         tests_failed++;
         $display("FAIL fetch0_pc: PC=%h cnt=%0d, required 00000004 1", PC, fetch_count);
      end
   endtask

   task automatic test_fetch_wait();
      @(negedge clk);
      idle_inputs();
      IRWrite   = 1'b1;
      PCWrite   = 1'b1;
      ALUResult = 32'h0000_0008;
      mem_rdata = 32'h2009_0005;
      mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         tests_run++;
         if (Stall !== 1'b1 || mem_addr !== 32'h4) begin
            tests_failed++;
            $display("FAIL wait%0d_stall: Stall=%b addr=%h, required 1 00000004", i, Stall, mem_addr);
         end
         @(posedge clk);
         #1;
         tests_run++;
         if (PC !== 32'h4 || Instr !== 32'h8C08_0004 || fetch_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL wait%0d_hold: PC=%h Instr=%h cnt=%0d, required 00000004 8c080004 1",
                     i, PC, Instr, fetch_count);
         end
         @(negedge clk);
      end
      mem_ready = 1'b1;
      #1;
      tests_run++;
      if (Stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL wait_release: Stall=%b, required 0", Stall);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (PC !== 32'h8 || Instr !== 32'h2009_0005 || Opcode !== 6'b001000 || fetch_count !== 32'd2) begin
         tests_failed++;
         $display("FAIL wait_update: PC=%h Instr=%h Opcode=%b cnt=%0d, required 00000008 20090005 001000 2",
                  PC, Instr, Opcode, fetch_count);
      end
   endtask

   task automatic test_load();
      @(negedge clk);
      idle_inputs();
      lord      = 1'b1;
      ALUOut    = 32'h0000_0040;
      mem_rdata = 32'hDEAD_BEEF;
      #1;
      tests_run++;
      if (mem_addr !== 32'h40 || mem_re !== 1'b1 || mem_we !== 1'b0 || Stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_port: addr=%h re=%b we=%b stall=%b, required 00000040 1 0 0",
                  mem_addr, mem_re, mem_we, Stall);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (Data !== 32'hDEAD_BEEF || Instr !== 32'h2009_0005 || PC !== 32'h8 || fetch_count !== 32'd2) begin
         tests_failed++;
         $display("FAIL load_regs: Data=%h Instr=%h PC=%h cnt=%0d, required deadbeef 20090005 00000008 2",
                  Data, Instr, PC, fetch_count);
      end
   endtask

   task automatic test_store();
      @(negedge clk);
      idle_inputs();
      lord      = 1'b1;
      MemWrite  = 1'b1;
      ALUOut    = 32'h0000_0080;
      WriteData = 32'h1234_5678;
      mem_rdata = 32'h5555_5555;
      mem_ready = 1'b0;
      #1;
      // A pending write stalls just like a read.
      tests_run++;
      if (Stall !== 1'b1 || mem_we !== 1'b1 || mem_re !== 1'b0) begin
         tests_failed++;
         $display("FAIL store_wait: Stall=%b we=%b re=%b, required 1 1 0", Stall, mem_we, mem_re);
      end
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      tests_run++;
      if (mem_addr !== 32'h80 || mem_wdata !== 32'h1234_5678 || mem_we !== 1'b1 ||
          mem_re !== 1'b0 || Stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL store_port: addr=%h wdata=%h we=%b re=%b stall=%b, required 00000080 12345678 1 0 0",
                  mem_addr, mem_wdata, mem_we, mem_re, Stall);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (Data !== 32'hDEAD_BEEF || Instr !== 32'h2009_0005) begin
         tests_failed++;
         $display("FAIL store_regs: Data=%h Instr=%h, required deadbeef 20090005", Data, Instr);
      end
   endtask

   task automatic test_branch();
      @(negedge clk);
      idle_inputs();
      Branch    = 1'b1;
      PCSrc     = 1'b1;
      Zero      = 1'b1;
      ALUOut    = 32'h0000_0100;
      ALUResult = 32'h0000_0300;
      mem_ready = 1'b0;   // no access this cycle, so no stall regardless
      #1;
      tests_run++;
      if (Stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL branch_taken_stall: Stall=%b, required 0", Stall);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (PC !== 32'h100) begin
         tests_failed++;
         $display("FAIL branch_taken_pc: PC=%h, required 00000100", PC);
      end
      @(negedge clk);
      Zero   = 1'b0;
      ALUOut = 32'h0000_0200;
      #1;
      tests_run++;
      if (Stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL branch_nt_stall: Stall=%b, required 0", Stall);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (PC !== 32'h100) begin
         tests_failed++;
         $display("FAIL branch_nt_pc: PC=%h, required 00000100", PC);
      end
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      idle_inputs();
      IRWrite   = 1'b1;
      PCWrite   = 1'b1;
      ALUResult = 32'h0000_0104;
      mem_rdata = 32'hAAAA_AAAA;
      mem_ready = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if (PC !== 32'h0 || Instr !== 32'h0 || Data !== 32'h0 || fetch_count !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_mid: PC=%h Instr=%h Data=%h cnt=%0d, required all zero",
                  PC, Instr, Data, fetch_count);
      end
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      // Same fetch now completes from the reset PC.
      tests_run++;
      if (PC !== 32'h104 || Instr !== 32'hAAAA_AAAA || fetch_count !== 32'd1) begin
         tests_failed++;
         $display("FAIL reset_mid_resume: PC=%h Instr=%h cnt=%0d, required 00000104 aaaaaaaa 1",
                  PC, Instr, fetch_count);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      ALUResult    = 32'h0;
      ALUOut       = 32'h0;
      WriteData    = 32'h0;
      mem_rdata    = 32'h0;
      idle_inputs();
      test_reset();
      test_fetch_zero_wait();
      test_fetch_wait();
      test_load();
      test_store();
      test_branch();
      test_reset_mid_access();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mc_fetch_datapath.md
Name: mc_fetch_datapath

Overview:
- State-holding datapath partner of the multicycle MIPS control FSM (main_decoder): consumes its control outputs (PCWrite, Branch, PCSrc, IRWrite, lord, MemWrite) and returns Opcode/Funct to it.
- Owns PC, instruction register (IR) and memory data register (MDR), plus the unified instruction/data memory port with ready-based wait states.
- Drives Stall; top level uses it to freeze the control FSM during memory wait states.

Parameters:
- WIDTH, 32, data/address width
- RESET_PC, 32'h0000_0000, PC value after reset
- CNT_W, 32, width of retired-fetch counter

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- PCWrite  in  1  unconditional PC update (fetch, jump)
- Branch  in  1  conditional PC update (beq)
- PCSrc  in  1  PC source select: 0 = ALUResult, 1 = ALUOut
- IRWrite  in  1  load IR from memory
- lord  in  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  in  1  memory write request
- Zero  in  1  ALU zero flag
- ALUResult  in  WIDTH  combinational ALU result
- ALUOut  in  WIDTH  registered ALU result
- WriteData  in  WIDTH  store data (register B)
- mem_rdata  in  WIDTH  memory read data
- mem_ready  in  1  memory completes access this cycle
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- PC  out  WIDTH  program counter
- Instr  out  WIDTH  IR contents
- Opcode  out  6  Instr[31:26] to main_decoder
- Funct  out  6  Instr[5:0] to ALU decoder
- Data  out  WIDTH  MDR contents
- Stall  out  1  memory access pending, hold all state
- fetch_count  out  CNT_W  completed instruction fetches

Behaviour:
- Reset (rst low, async): PC = RESET_PC; Instr = 0 (Opcode = 6'b000000); Data = 0; fetch_count = 0.
- Reset mid-access: PC = RESET_PC, Instr = 0, Data = 0, fetch_count = 0, same as any other reset; no pending state survives.
- Combinational outputs (no reset value):
  - mem_addr = lord ? ALUOut : PC
  - mem_wdata = WriteData
  - mem_we = MemWrite
  - mem_re = (IRWrite | lord) & ~MemWrite
- Access = mem_we | mem_re. Stall = Access & ~mem_ready (combinational).
- All registers update only on cycles with Stall = 0. Every stalled cycle holds PC, IR, MDR and fetch_count.
- Control inputs must stay stable across stalled cycles; this is guaranteed by the top-level FSM freeze.
- PCEn = PCWrite | (Branch & Zero). On PCEn & ~Stall: PC <= PCSrc ? ALUOut : ALUResult.
- On IRWrite & ~Stall: Instr <= mem_rdata; fetch_count <= fetch_count + 1.
  - fetch_count wraps modulo 2^CNT_W.
- On mem_re & lord & ~Stall: Data <= mem_rdata. In all other cycles MDR holds.
- Same-cycle fetch: IRWrite and PCWrite both high in the fetch state. IR captures the word at the old PC and the PC advances in the same edge.
- A PC update with no memory access (branch or jump state) never stalls.
- Precedence: MemWrite high suppresses mem_re even if IRWrite or lord is also high. IR/MDR do not load on a write cycle.
- Branch with Zero = 0 and PCWrite = 0 leaves PC unchanged.
- Latency:
  - zero-wait memory (mem_ready tied high): every update at the next rising edge.
  - N wait cycles: update N edges later.

Test Plan:
- Reset: rst low at t=3 (asynchronous, mid-cycle) -> PC = 0, Instr = 0, Opcode = 0, Data = 0, fetch_count = 0 immediately, before the next clock edge.
- Fetch with zero-wait memory: PC = 0x00, mem_rdata = 0x8C08_0004, IRWrite = PCWrite = 1, PCSrc = 0, ALUResult = 0x04, mem_ready = 1 -> one edge later Instr = 0x8C08_0004, Opcode = 6'b100011, PC = 0x04, fetch_count = 1.
- Fetch with 2 wait cycles: mem_ready low for 2 cycles -> Stall = 1 for 2 cycles, PC/IR unchanged. Update on the edge after mem_ready rises.
- Load: lord = 1, ALUOut = 0x40, mem_rdata = 0xDEAD_BEEF, mem_ready = 1 -> mem_addr = 0x40, mem_re = 1, Data = 0xDEAD_BEEF next edge, Instr unchanged.
- Store: lord = 1, MemWrite = 1, ALUOut = 0x80, WriteData = 0x1234_5678 -> mem_we = 1, mem_re = 0, mem_addr = 0x80, mem_wdata = 0x1234_5678, Data unchanged.
- Branch: Branch = 1, PCSrc = 1, ALUOut = 0x100, Zero = 1 -> PC = 0x100. Repeat with Zero = 0 -> PC unchanged, Stall = 0.
